apb_gpio_arbiter: RTL and testbench

Two-requester APB bus master that shares one APB slave, typically the 32-bit GPIO port, between a CPU-side requester (port 0) and the DMAC (port 1).
- Converts each requester's simple req/ack transaction into a compliant APB SETUP/ACCESS sequence.
- Arbitrates round-robin and returns read data and a completion pulse to the winning requester.
- Sits between the requesters and the GPIO PSEL/PADDR/PRDATA port.

---
 rtl/apb_gpio_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_apb_gpio_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_arbiter.sv
// Two-requester round-robin APB master sharing one APB slave (typically the GPIO port).
// Optional ACCESS-phase timeout is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_gpio_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          write0,
    input  logic          write1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic          PREADY,
    input  logic [DW-1:0] PRDATA,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          owner_nxt;
    logic          last_grant;
    logic          last_grant_nxt;
    logic          win;
    logic          psel_nxt;
    logic          penable_nxt;
    logic          pwrite_nxt;
    logic          busy_nxt;
    logic          ack0_nxt;
    logic          ack1_nxt;
    logic [AW-1:0] paddr_nxt;
    logic [DW-1:0] pwdata_nxt;
    logic [DW-1:0] rdata0_nxt;
    logic [DW-1:0] rdata1_nxt;

    // A tie goes to the requester that did not win the previous grant.
    assign win = (req0 && req1) ? ~last_grant : req1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("apb_gpio_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err0_nxt;
    logic             err1_nxt;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        psel_nxt       = PSEL;
        penable_nxt    = PENABLE;
        pwrite_nxt     = PWRITE;
        paddr_nxt      = PADDR;
        pwdata_nxt     = PWDATA;
        rdata0_nxt     = rdata0;
        rdata1_nxt     = rdata1;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_nxt        = cnt;
        err0_nxt       = err0;
        err1_nxt       = err1;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nxt      = win;
                    last_grant_nxt = win;
                    paddr_nxt      = win ? addr1  : addr0;
                    pwrite_nxt     = win ? write1 : write0;
                    pwdata_nxt     = win ? wdata1 : wdata0;
                    psel_nxt       = 1'b1;
                    state_nxt      = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_nxt     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = DONE;
                    if (owner) begin
                        ack1_nxt = 1'b1;
                        if (!PWRITE) rdata1_nxt = PRDATA;
                    end else begin
                        ack0_nxt = 1'b1;
                        if (!PWRITE) rdata0_nxt = PRDATA;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    if (owner) err1_nxt = 1'b0;
                    else       err0_nxt = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = DONE;
                    if (owner) begin
                        ack1_nxt   = 1'b1;
                        rdata1_nxt = DW'(32'hDEADBEEF);
                        err1_nxt   = 1'b1;
                    end else begin
                        ack0_nxt   = 1'b1;
                        rdata0_nxt = DW'(32'hDEADBEEF);
                        err0_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt        <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            PSEL       <= psel_nxt;
            PENABLE    <= penable_nxt;
            PWRITE     <= pwrite_nxt;
            PADDR      <= paddr_nxt;
            PWDATA     <= pwdata_nxt;
            rdata0     <= rdata0_nxt;
            rdata1     <= rdata1_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            busy       <= busy_nxt;
`ifdef APB_ARB_TIMEOUT_EN
            cnt        <= cnt_nxt;
            err0       <= err0_nxt;
            err1       <= err1_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Directed bench for apb_gpio_arbiter with an expected-completion scoreboard.
// Timeout expectations follow APB_ARB_TIMEOUT_EN when it is defined.
module tb_apb_gpio_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req0, req1, write0, write1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          PSEL, PENABLE, PWRITE, PREADY, busy;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_gpio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .write0(write0), .write1(write1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .busy(busy)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Waits (bounded) for any ack; cyc is the number of edges from the caller's cycle.
    task automatic wait_ack(input string tag, input int limit, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(ack0 || ack1) && cyc < limit);
        check({tag, "_ack_seen"}, DW'(ack0 | ack1), DW'(1));
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, DW'(sb.size() != 0), DW'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_ack0"}, DW'(ack0), DW'(!e.port));
        check({tag, "_ack1"}, DW'(ack1), DW'(e.port));
        check({tag, "_paddr"}, PADDR, e.addr);
        check({tag, "_rdata"}, e.port ? rdata1 : rdata0, e.rdata);
        check({tag, "_err"}, DW'(e.port ? err1 : err0), DW'(e.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic seen;

        PRESET = 1'b1;
        req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        PREADY = 1'b0; PRDATA = '0;
        tick(2);
        check("rst_psel", DW'(PSEL), DW'(0));
        check("rst_penable", DW'(PENABLE), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_acks", DW'({ack0, ack1}), DW'(0));
        check("rst_paddr", PADDR, '0);
        check("rst_rdata0", rdata0, '0);
        PRESET = 1'b0;
        tick();

        // Zero-wait write from requester 0.
        req0 = 1'b1; write0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hFF; PREADY = 1'b1;
        sb.push_back('{1'b0, 32'h4, 32'h0, 1'b0});
        tick();
        check("wr_setup_psel", DW'(PSEL), DW'(1));
        check("wr_setup_penable", DW'(PENABLE), DW'(0));
        tick();
        check("wr_access_penable", DW'(PENABLE), DW'(1));
        check("wr_access_paddr", PADDR, 32'h4);
        check("wr_access_pwdata", PWDATA, 32'hFF);
        check("wr_access_pwrite", DW'(PWRITE), DW'(1));
        tick();
        sb_check("wr");
        check("wr_done_psel", DW'(PSEL), DW'(0));
        req0 = 1'b0;
        tick();
        check("wr_idle_busy", DW'(busy), DW'(0));
        check("wr_idle_ack0", DW'(ack0), DW'(0));

        // Read from requester 1 with two wait states.
        req1 = 1'b1; write1 = 1'b0; addr1 = 32'h0; PRDATA = 32'h12345678; PREADY = 1'b0;
        sb.push_back('{1'b1, 32'h0, 32'h12345678, 1'b0});
        tick(2);
        check("rd_access1_penable", DW'(PENABLE), DW'(1));
        tick();
        check("rd_access2_penable", DW'(PENABLE), DW'(1));
        check("rd_access2_ack1", DW'(ack1), DW'(0));
        tick();
        PREADY = 1'b1;
        check("rd_access3_penable", DW'(PENABLE), DW'(1));
        tick();
        sb_check("rd");
        req1 = 1'b0;
        tick();

        // Both requesters held from reset: grants alternate, 4 cycles apart.
        PRESET = 1'b1;
        req0 = 1'b1; write0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hA5;
        req1 = 1'b1; write1 = 1'b0; addr1 = 32'h20; PRDATA = 32'hCAFEF00D; PREADY = 1'b1;
        tick();
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{1'b0, 32'h10, 32'h0, 1'b0});
            else            sb.push_back('{1'b1, 32'h20, 32'hCAFEF00D, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("rr%0d", i), 8, cyc);
            check($sformatf("rr%0d_latency", i), DW'(cyc), (i == 0) ? DW'(3) : DW'(4));
            if (ack0 || ack1) sb_check($sformatf("rr%0d", i));
            else if (sb.size() != 0) void'(sb.pop_front());
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Reset mid-ACCESS after a requester-0 grant; next tie must still go to 0.
        req0 = 1'b1; write0 = 1'b0; addr0 = 32'h30; PREADY = 1'b0;
        tick(2);
        check("abort_penable_before", DW'(PENABLE), DW'(1));
        #2 PRESET = 1'b1;
        #1;
        check("abort_psel", DW'(PSEL), DW'(0));
        check("abort_penable", DW'(PENABLE), DW'(0));
        check("abort_busy", DW'(busy), DW'(0));
        req0 = 1'b0;
        #1 PRESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | ack0 | ack1;
        end
        check("abort_no_ack", DW'(seen), DW'(0));
        req0 = 1'b1; write0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h1;
        req1 = 1'b1; write1 = 1'b1; addr1 = 32'h50; wdata1 = 32'h2; PREADY = 1'b1;
        sb.push_back('{1'b0, 32'h40, 32'h0, 1'b0});
        wait_ack("post_rst", 8, cyc);
        check("post_rst_latency", DW'(cyc), DW'(3));
        if (ack0 || ack1) sb_check("post_rst");
        else if (sb.size() != 0) void'(sb.pop_front());
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Slave never ready.
        req0 = 1'b1; write0 = 1'b0; addr0 = 32'h60; PRDATA = 32'h11111111; PREADY = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 32'h60, 32'hDEADBEEF, 1'b1});
        wait_ack("tmo", 30, cyc);
        check("tmo_latency", DW'(cyc), DW'(18));
        if (ack0 || ack1) sb_check("tmo");
        else if (sb.size() != 0) void'(sb.pop_front());
`else
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | ack0 | ack1;
        end
        check("stall_no_ack", DW'(seen), DW'(0));
        check("stall_psel", DW'(PSEL), DW'(1));
        check("stall_penable", DW'(PENABLE), DW'(1));
        check("stall_busy", DW'(busy), DW'(1));
        check("stall_err0", DW'(err0), DW'(0));
        sb.push_back('{1'b0, 32'h60, 32'h11111111, 1'b0});
        PREADY = 1'b1;
        wait_ack("stall_release", 4, cyc);
        check("stall_release_latency", DW'(cyc), DW'(1));
        if (ack0 || ack1) sb_check("stall_release");
        else if (sb.size() != 0) void'(sb.pop_front());
`endif
        req0 = 1'b0;
        tick(2);
        check("final_busy", DW'(busy), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
